alu_mc: RTL and testbench
=========================

Name: alu_mc

Overview:
- Parametrised, registered, multi-cycle ALU for the MIPS datapath; next generation of the single-cycle ALU.
- Generalises the datapath to WIDTH bits, registers all results, and adds signed/unsigned multiply and divide with HI/LO results.
- Uses a valid/ready handshake so the control unit can stall while an iterative operation runs.
- Sits in EX stage, between the register-file read ports and the EX/MEM pipeline register.

Parameters:
- WIDTH, 32, operand/result width in bits (>=8).
- OPW, 4, opcode width.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands/op present.
- in_ready  output  1  block can accept; high only in IDLE.
- op  input  OPW  operation select.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- out_valid  output  1  one-cycle pulse: result registers updated.
- result  output  WIDTH  ALU result / LO (product low, quotient).
- result_hi  output  WIDTH  HI (product high, remainder); 0 for single-cycle ops.
- zero  output  1  result == 0, registered with result.
- overflow  output  1  signed overflow for ADD/SUB, else 0.
- busy  output  1  multi-cycle operation in progress.

Behaviour:
- Clock and reset: one clock (clk); rst synchronous, active-high. On rst: state=IDLE, result=0, result_hi=0, zero=0, overflow=0, out_valid=0, busy=0. in_ready=1 after reset.
- Opcodes, single-cycle: 0000 AND, 0001 OR, 0011 XOR, 1100 NOR, 0010 ADD, 0110 SUB, 0111 SLT (signed, result 0/1), 0101 SLTU.
- Opcodes, multi-cycle: 1000 MULT (signed), 1001 MULTU, 1010 DIV (signed), 1011 DIVU.
- Accept: a transfer occurs on a rising edge with in_valid && in_ready.
- Single-cycle op: result, zero and overflow are registered at the accept edge. out_valid is high for the following cycle. Back-to-back accepts are allowed every cycle.
- ADD/SUB arithmetic: modulo 2^WIDTH; the carry is discarded.
- ADD overflow: operands share a sign and the sum sign differs.
- SUB overflow: operand signs differ and the result sign differs from A.
- FSM states: IDLE, MUL, DIV.
- IDLE -> MUL/DIV on accept of a multi-cycle op. Operands are latched; signed ops take absolute values and record the result signs.
- MUL: radix-2 shift-add, one bit per cycle, counter WIDTH-1 down to 0.
- DIV: restoring shift-subtract, one bit per cycle, same counter.
- MUL/DIV -> IDLE on the cycle the counter reaches 0. Sign correction is applied and {result_hi,result} are written. out_valid pulses the next cycle.
- Multi-cycle latency: out_valid asserted exactly WIDTH+1 cycles after the accept edge (33 at WIDTH=32).
- While busy: in_ready=0 and in_valid is ignored. busy=1 in MUL/DIV.
- zero for multi-cycle ops: reflects result (LO) only.
- Signed divide: quotient truncates toward zero; remainder takes the sign of the dividend.
- Divide by zero: result = all ones, result_hi = A; still takes WIDTH+1 cycles.
- Signed MIN / -1: result = MIN, result_hi = 0, overflow = 0.
- Undefined opcode: single-cycle; result=0, result_hi=0, zero=1, out_valid pulses.
- No output backpressure: out_valid is a pulse, and result/result_hi/zero/overflow hold until the next out_valid.
- rst mid-operation: aborts, returns to IDLE, and clears outputs; no out_valid for the aborted op.

Optional Feature:
- Macro: ALU_DIV_EN.
- Defined: DIV/DIVU are supported as above (DIV state and divider datapath compiled in).
- Undefined: DIV state and divider logic are compiled out; 1010/1011 behave as undefined opcodes (single-cycle, result=0, result_hi=0, zero=1). MULT/MULTU are unaffected.

Test Plan:
- Reset, then ADD A=0x7FFFFFFF, B=1 -> next cycle out_valid=1, result=0x80000000, overflow=1, zero=0.
- SUB A=5, B=5, followed next cycle by SLT A=0xFFFFFFFF, B=1 -> out_valid on consecutive cycles: result=0 with zero=1, then result=1.
- MULT A=0xFFFFFFFE (-2), B=3 -> in_ready=0 for 33 cycles; out_valid 33 cycles after accept; result_hi=0xFFFFFFFF, result=0xFFFFFFFA.
- DIV A=-7 (0xFFFFFFF9), B=2 -> result=0xFFFFFFFD (-3), result_hi=0xFFFFFFFF (-1). DIVU A=10, B=0 -> result=0xFFFFFFFF, result_hi=10. Without ALU_DIV_EN: both give result=0, zero=1 after 1 cycle.
- MULTU 0xFFFFFFFF x 0xFFFFFFFF, rst asserted at cycle 10 -> no out_valid; outputs=0; in_ready=1; a following AND 0xF0F0, 0x0FF0 -> result=0x00F0.
- Undefined op 1111 with A=B=0x1234 -> out_valid next cycle, result=0, result_hi=0, zero=1.

Source files
------------

// File: rtl/alu_mc.sv
// rtl/alu_mc.sv - registered multi-cycle MIPS ALU with shift-add multiply and restoring divide.
// Optional divider is compiled in only when ALU_DIV_EN is defined.
module alu_mc #(
  parameter int WIDTH = 32,
  parameter int OPW   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OPW-1:0]   op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             zero,
  output logic             overflow,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [OPW-1:0] OP_AND   = OPW'(4'b0000);
  localparam logic [OPW-1:0] OP_OR    = OPW'(4'b0001);
  localparam logic [OPW-1:0] OP_XOR   = OPW'(4'b0011);
  localparam logic [OPW-1:0] OP_NOR   = OPW'(4'b1100);
  localparam logic [OPW-1:0] OP_ADD   = OPW'(4'b0010);
  localparam logic [OPW-1:0] OP_SUB   = OPW'(4'b0110);
  localparam logic [OPW-1:0] OP_SLT   = OPW'(4'b0111);
  localparam logic [OPW-1:0] OP_SLTU  = OPW'(4'b0101);
  localparam logic [OPW-1:0] OP_MULT  = OPW'(4'b1000);
  localparam logic [OPW-1:0] OP_MULTU = OPW'(4'b1001);
`ifdef ALU_DIV_EN
  localparam logic [OPW-1:0] OP_DIV   = OPW'(4'b1010);
  localparam logic [OPW-1:0] OP_DIVU  = OPW'(4'b1011);
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL
`ifdef ALU_DIV_EN
    , S_DIV
`endif
  } state_t;

  state_t           r_state, w_next;
  logic [CW-1:0]    r_cnt;
  logic             r_fin;
  logic [WIDTH-1:0] r_acc, r_lo, r_b;
  logic             r_neg_lo;
  logic [WIDTH-1:0] r_result, r_result_hi;
  logic             r_zero, r_ovf, r_out_valid;
`ifdef ALU_DIV_EN
  logic             r_neg_hi, r_dz;
  logic [WIDTH:0]   w_trial;
  logic [WIDTH-1:0] w_q_fix, w_r_fix;
`endif

  logic             w_accept, w_is_mul, w_is_div, w_signed, w_a_neg, w_b_neg;
  logic [WIDTH-1:0] w_a_abs, w_b_abs, w_add, w_sub, w_sc_res;
  logic             w_sc_ovf;
  logic [WIDTH:0]   w_sum;
  logic [2*WIDTH-1:0] w_prod, w_prod_fix;

  assign w_accept = in_valid && (r_state == S_IDLE);
  assign w_is_mul = (op == OP_MULT) || (op == OP_MULTU);
`ifdef ALU_DIV_EN
  assign w_is_div = (op == OP_DIV) || (op == OP_DIVU);
  assign w_signed = (op == OP_MULT) || (op == OP_DIV);
`else
  assign w_is_div = 1'b0;
  assign w_signed = (op == OP_MULT);
`endif
  // Signed ops iterate on magnitudes; signs are reapplied on the final cycle.
  assign w_a_neg  = w_signed && A[WIDTH-1];
  assign w_b_neg  = w_signed && B[WIDTH-1];
  assign w_a_abs  = w_a_neg ? -A : A;
  assign w_b_abs  = w_b_neg ? -B : B;
  assign w_add    = A + B;
  assign w_sub    = A - B;

  always_comb begin
    w_sc_res = '0;
    w_sc_ovf = 1'b0;
    case (op)
      OP_AND:  w_sc_res = A & B;
      OP_OR:   w_sc_res = A | B;
      OP_XOR:  w_sc_res = A ^ B;
      OP_NOR:  w_sc_res = ~(A | B);
      OP_ADD: begin
        w_sc_res = w_add;
        w_sc_ovf = (A[WIDTH-1] == B[WIDTH-1]) && (w_add[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SUB: begin
        w_sc_res = w_sub;
        w_sc_ovf = (A[WIDTH-1] != B[WIDTH-1]) && (w_sub[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SLT:  w_sc_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      OP_SLTU: w_sc_res = {{(WIDTH-1){1'b0}}, (A < B)};
      default: w_sc_res = '0;
    endcase
  end

  assign w_sum      = {1'b0, r_acc} + (r_lo[0] ? {1'b0, r_b} : '0);
  assign w_prod     = {r_acc, r_lo};
  assign w_prod_fix = r_neg_lo ? -w_prod : w_prod;
`ifdef ALU_DIV_EN
  // Top bit of the trial difference is the borrow: set means restore.
  assign w_trial = {r_acc, r_lo[WIDTH-1]} - {1'b0, r_b};
  assign w_q_fix = r_dz ? '1 : (r_neg_lo ? -r_lo : r_lo);
  assign w_r_fix = r_neg_hi ? -r_acc : r_acc;
`endif

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    in_ready = 1'b0;
    busy     = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (w_accept && w_is_mul) w_next = S_MUL;
`ifdef ALU_DIV_EN
        else if (w_accept && w_is_div) w_next = S_DIV;
`endif
      end
      S_MUL: begin
        busy = 1'b1;
        if (r_fin) w_next = S_IDLE;
      end
`ifdef ALU_DIV_EN
      S_DIV: begin
        busy = 1'b1;
        if (r_fin) w_next = S_IDLE;
      end
`endif
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0; r_fin <= 1'b0; r_acc <= '0; r_lo <= '0; r_b <= '0;
      r_neg_lo <= 1'b0; r_result <= '0; r_result_hi <= '0;
      r_zero <= 1'b0; r_ovf <= 1'b0; r_out_valid <= 1'b0;
`ifdef ALU_DIV_EN
      r_neg_hi <= 1'b0; r_dz <= 1'b0;
`endif
    end else begin
      r_out_valid <= 1'b0;
      case (r_state)
        S_IDLE: if (w_accept) begin
          if (w_is_mul || w_is_div) begin
            r_cnt    <= CW'(WIDTH-1);
            r_fin    <= 1'b0;
            r_acc    <= '0;
            r_lo     <= w_a_abs;
            r_b      <= w_b_abs;
            r_neg_lo <= w_a_neg ^ w_b_neg;
`ifdef ALU_DIV_EN
            r_neg_hi <= w_a_neg;
            r_dz     <= (B == '0);
`endif
          end else begin
            r_result    <= w_sc_res;
            r_result_hi <= '0;
            r_zero      <= (w_sc_res == '0);
            r_ovf       <= w_sc_ovf;
            r_out_valid <= 1'b1;
          end
        end
        S_MUL: if (r_fin) begin
          {r_result_hi, r_result} <= w_prod_fix;
          r_zero      <= (w_prod_fix[WIDTH-1:0] == '0);
          r_ovf       <= 1'b0;
          r_out_valid <= 1'b1;
        end else begin
          r_acc <= w_sum[WIDTH:1];
          r_lo  <= {w_sum[0], r_lo[WIDTH-1:1]};
          r_cnt <= r_cnt - CW'(1);
          r_fin <= (r_cnt == '0);
        end
`ifdef ALU_DIV_EN
        S_DIV: if (r_fin) begin
          r_result    <= w_q_fix;
          r_result_hi <= w_r_fix;
          r_zero      <= (w_q_fix == '0);
          r_ovf       <= 1'b0;
          r_out_valid <= 1'b1;
        end else begin
          r_acc <= w_trial[WIDTH] ? {r_acc[WIDTH-2:0], r_lo[WIDTH-1]} : w_trial[WIDTH-1:0];
          r_lo  <= {r_lo[WIDTH-2:0], ~w_trial[WIDTH]};
          r_cnt <= r_cnt - CW'(1);
          r_fin <= (r_cnt == '0);
        end
`endif
        default: ;
      endcase
    end
  end

  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign result_hi = r_result_hi;
  assign zero      = r_zero;
  assign overflow  = r_ovf;

endmodule

// File: tb/tb_alu_mc.sv
// tb/tb_alu_mc.sv - directed self-checking bench for alu_mc.
// Expectations follow ALU_DIV_EN when it is defined for the build.
module tb_alu_mc;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  op = 4'h0;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic        out_valid;
  logic [31:0] result, result_hi;
  logic        zero, overflow, busy;

  int n_checks = 0;
  int n_errors = 0;

  alu_mc #(.WIDTH(32), .OPW(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .A(A), .B(B), .out_valid(out_valid), .result(result),
    .result_hi(result_hi), .zero(zero), .overflow(overflow), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    op = o; A = a; B = b; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Called #1 after the accept edge; counts edges until out_valid.
  task automatic wait_done(output int lat, output int rdy_low);
    lat = 0;
    rdy_low = in_ready ? 0 : 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
      if (!in_ready) rdy_low++;
    end
  endtask

  task automatic single(input string tag, input logic [3:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res,
                        input logic exp_z, input logic exp_ovf);
    issue(o, a, b);
    check({tag, "_valid"}, out_valid, 1'b1);
    check({tag, "_res"}, result, exp_res);
    check({tag, "_hi"}, result_hi, 32'h0);
    check({tag, "_zero"}, zero, exp_z);
    check({tag, "_ovf"}, overflow, exp_ovf);
  endtask

  logic [3:0]  t_op  [6] = '{4'b0001, 4'b0011, 4'b1100, 4'b0101, 4'b0110, 4'b0010};
  logic [31:0] t_a   [6] = '{32'hF0F0, 32'hF0F0, 32'h0, 32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFF};
  logic [31:0] t_b   [6] = '{32'h0FF0, 32'h0FF0, 32'h0, 32'h1, 32'h1, 32'h1};
  logic [31:0] t_res [6] = '{32'hFFF0, 32'hFF00, 32'hFFFFFFFF, 32'h0, 32'h7FFFFFFF, 32'h0};
  logic        t_z   [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
  logic        t_ovf [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

  initial begin
    int lat, low, pulses;
    repeat (2) @(posedge clk);
    #1;
    check("rst_res", result, 32'h0);
    check("rst_hi", result_hi, 32'h0);
    check("rst_zero", zero, 1'b0);
    check("rst_ovf", overflow, 1'b0);
    check("rst_valid", out_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_ready", in_ready, 1'b1);
    rst = 1'b0;

    single("add_ovf", 4'b0010, 32'h7FFFFFFF, 32'h1, 32'h80000000, 1'b0, 1'b1);
    single("sub_eq", 4'b0110, 32'h5, 32'h5, 32'h0, 1'b1, 1'b0);
    single("slt_neg", 4'b0111, 32'hFFFFFFFF, 32'h1, 32'h1, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++)
      single($sformatf("vec%0d", i), t_op[i], t_a[i], t_b[i], t_res[i], t_z[i], t_ovf[i]);

    // MULT with a competing request held during busy; it must be ignored.
    issue(4'b1000, 32'hFFFFFFFE, 32'h3);
    check("mult_busy", busy, 1'b1);
    op = 4'b0000; A = 32'h1; B = 32'h1; in_valid = 1'b1;
    wait_done(lat, low);
    in_valid = 1'b0;
    check("mult_lat", lat, 33);
    check("mult_rdy_low", low, 33);
    check("mult_lo", result, 32'hFFFFFFFA);
    check("mult_hi", result_hi, 32'hFFFFFFFF);
    check("mult_zero", zero, 1'b0);
    @(posedge clk); #1;
    check("mult_pulse_end", out_valid, 1'b0);

    issue(4'b1001, 32'h00010000, 32'h00010000);
    wait_done(lat, low);
    check("multu_lo", result, 32'h0);
    check("multu_hi", result_hi, 32'h1);
    check("multu_zero", zero, 1'b1);

    issue(4'b1001, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_done(lat, low);
    check("multu_max", {result_hi, result}, 64'hFFFFFFFE_00000001);

`ifdef ALU_DIV_EN
    issue(4'b1010, 32'hFFFFFFF9, 32'h2);
    wait_done(lat, low);
    check("div_lat", lat, 33);
    check("div_q", result, 32'hFFFFFFFD);
    check("div_r", result_hi, 32'hFFFFFFFF);
    issue(4'b1011, 32'hA, 32'h0);
    wait_done(lat, low);
    check("divz_lat", lat, 33);
    check("divz_q", result, 32'hFFFFFFFF);
    check("divz_r", result_hi, 32'hA);
    issue(4'b1010, 32'h80000000, 32'hFFFFFFFF);
    wait_done(lat, low);
    check("divmin_q", result, 32'h80000000);
    check("divmin_r", result_hi, 32'h0);
    check("divmin_ovf", overflow, 1'b0);
`else
    single("div_off", 4'b1010, 32'hFFFFFFF9, 32'h2, 32'h0, 1'b1, 1'b0);
    single("divu_off", 4'b1011, 32'hA, 32'h0, 32'h0, 1'b1, 1'b0);
    single("add_pre", 4'b0010, 32'h1, 32'h1, 32'h2, 1'b0, 1'b0);
`endif

    // Abort a long MULTU with reset partway through.
    issue(4'b1001, 32'hFFFFFFFF, 32'hFFFFFFFF);
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_res", result, 32'h0);
    check("abort_hi", result_hi, 32'h0);
    check("abort_ready", in_ready, 1'b1);
    check("abort_busy", busy, 1'b0);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (out_valid) pulses++;
    end
    check("abort_no_valid", pulses, 0);
    single("and_after", 4'b0000, 32'hF0F0, 32'h0FF0, 32'h00F0, 1'b0, 1'b0);
    single("undef", 4'b1111, 32'h1234, 32'h1234, 32'h0, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
